ray_sphere_intersect_seq: RTL
=============================

Name: ray_sphere_intersect_seq

Overview:
Sequential ray–sphere intersection unit that sits directly downstream of the Q8.4 fixed-point primitives and upstream of the shading/hit-compare stage. It accepts one ray (origin, unit direction) plus one sphere (center, radius) per transaction. It computes the nearest positive hit distance t using one shared multiplier and an iterative bit-serial square root, with fixed latency. Results are returned over a valid/ready handshake.

Parameters:
WIDTH, 12, word width of all Q8.4 signed operands and results
TAG_WIDTH, 4, width of opaque tag carried from input to output unchanged

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset, sampled on rising edge of clk
inValid  input  1  input transaction valid
inReady  output  1  block can accept; high only in IDLE
ox, oy, oz  input  WIDTH each  ray origin, Q8.4 signed
dx, dy, dz  input  WIDTH each  ray direction, Q8.4, caller guarantees unit length
cx, cy, cz  input  WIDTH each  sphere center, Q8.4 signed
radius  input  WIDTH  sphere radius, Q8.4, treated as signed
inTag  input  TAG_WIDTH  opaque tag
outValid  output  1  result valid; held until accepted
outReady  input  1  downstream accepts result
hit  output  1  1 = positive intersection found
tHit  output  WIDTH  hit distance Q8.4; 0 when hit=0
outTag  output  TAG_WIDTH  tag of this result

Behaviour:
- Reset: state=IDLE; inReady=1 (combinational from state); outValid=0, hit=0, tHit=0, outTag=0; all internal accumulators cleared. Reset wins over every other event, including mid-computation and during DONE. An in-flight result is discarded.
- Accept: at the edge where inValid && inReady, latch all inputs and inTag, then go to SUB. Inputs are ignored at all other times.
- States and cycles:
  - IDLE: wait for accept.
  - SUB: 1 cycle. Compute oc = o − c per component, wrapped to WIDTH.
  - MAC: 8 cycles, one signed WIDTHxWIDTH product per cycle. Each product is arithmetic-shifted right by 4 (truncating) and accumulated in 2*WIDTH+2 bits.
    - cycles 1–3: b = Σ oc_i·d_i
    - cycles 4–6: acc = Σ oc_i·oc_i
    - cycle 7: c = acc − (radius·radius>>>4)
    - cycle 8: disc = (b_sat·b_sat>>>4) − c
    - b_sat is b saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - SQRT: 8 cycles, restoring integer sqrt, 2 radicand bits per cycle.
    - radicand = clamp(disc, 0, 2^(WIDTH−1)−1) << 4 (16 bits)
    - s = floor(sqrt(radicand)), giving a Q8.4 root.
    - Always runs, even when disc<0; in that case the radicand is 0.
  - SEL: 1 cycle, computed in WIDTH+2 bits.
    - t0 = −b_sat − s; t1 = −b_sat + s.
    - If disc<0: miss.
    - Else if t0>0: t=t0.
    - Else if t1>0: t=t1.
    - Else: miss.
    - On hit, tHit = t saturated to 2^(WIDTH−1)−1; on miss, tHit=0.
    - Register hit/tHit/outTag, set outValid=1, go to DONE.
  - DONE: hold all outputs stable. On outValid && outReady: outValid=0, go to IDLE.
- Latency: accept at edge N gives outValid=1 after edge N+18, fixed and data-independent.
- Throughput: next accept earliest 1 cycle after the output handshake, because inReady=0 in DONE. No overlap of transactions.
- outReady is ignored outside DONE. inValid held high while busy has no effect.
- hit, tHit and outTag change only at the SEL→DONE edge or on reset.

Test Plan:
- Reset, then o=(0,0,0), d=(0,0,16), c=(0,0,80), r=16, tag=3 → outValid high exactly 18 cycles after accept; hit=1, tHit=64 (4.0), outTag=3; internal b=−80, c=384, disc=16, s=16.
- Miss: same ray, c=(0,80,80), r=16 → disc=−384; hit=0, tHit=0, latency still 18.
- Origin inside sphere: o=c=(0,0,80), d=(0,0,16), r=16 → t0=−16, t1=16; hit=1, tHit=16.
- Sphere behind: o=(0,0,0), d=(0,0,16), c=(0,0,−80), r=16 → t0=−96, t1=−64; hit=0, tHit=0.
- Backpressure: outReady=0 for 10 cycles after outValid → outputs stable, inReady=0, new inValid ignored. Raise outReady → outValid drops next edge, inReady=1; second transaction accepted and correct.
- Reset mid-op: assert rst in SQRT and separately in DONE → next cycle outValid=0, hit=0, tHit=0, inReady=1. Fresh transaction then gives the correct result with no stale data.

Source files
------------

// File: rtl/ray_sphere_intersect_seq.sv
// ray_sphere_intersect_seq: nearest positive ray/sphere hit distance in Q8.4 using one shared multiplier and a bit-serial sqrt
module ray_sphere_intersect_seq #(
  parameter int WIDTH = 12,
  parameter int TAG_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic signed [WIDTH-1:0]     ox,
  input  logic signed [WIDTH-1:0]     oy,
  input  logic signed [WIDTH-1:0]     oz,
  input  logic signed [WIDTH-1:0]     dx,
  input  logic signed [WIDTH-1:0]     dy,
  input  logic signed [WIDTH-1:0]     dz,
  input  logic signed [WIDTH-1:0]     cx,
  input  logic signed [WIDTH-1:0]     cy,
  input  logic signed [WIDTH-1:0]     cz,
  input  logic signed [WIDTH-1:0]     radius,
  input  logic [TAG_WIDTH-1:0]        inTag,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        hit,
  output logic [WIDTH-1:0]            tHit,
  output logic [TAG_WIDTH-1:0]        outTag
);
  localparam int AW = 2*WIDTH+2;
  localparam int RW = WIDTH+4;
  localparam int SW = RW/2;
  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0] A_MAX = AW'(2**(WIDTH-1)-1);
  localparam logic signed [AW-1:0] A_MIN = AW'(-(2**(WIDTH-1)));
  localparam logic signed [WIDTH+1:0] T_MAX = (WIDTH+2)'(2**(WIDTH-1)-1);
  typedef enum logic [2:0] {IDLE, SUB, MAC, SQRT, SEL, DONE} state_t;
  state_t state, next;
  logic signed [WIDTH-1:0] o [3];
  logic signed [WIDTH-1:0] d [3];
  logic signed [WIDTH-1:0] c [3];
  logic signed [WIDTH-1:0] r;
  logic [TAG_WIDTH-1:0] tag;
  logic [2:0] cnt;
  logic [1:0] idx;
  logic signed [AW-1:0] b, acc, disc, prod_sh, dnext;
  logic signed [WIDTH-1:0] ma, mb, bsat, oc_sel, d_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] dclamp;
  logic [RW-1:0] rad, rem, rem_sh, trial;
  logic [SW-1:0] root;
  logic signed [WIDTH+1:0] nb, t0, t1, tsel;
  logic sel_hit;
  logic [WIDTH-1:0] t_sat;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = inValid ? SUB : IDLE;
      SUB:  next = MAC;
      MAC:  next = (cnt == 3'd7) ? SQRT : MAC;
      SQRT: next = (cnt == 3'(SW-1)) ? SEL : SQRT;
      SEL:  next = DONE;
      DONE: next = outReady ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  assign inReady = (state == IDLE);
  // o holds o-c after SUB; multiplier operands walk b, |oc|^2, r^2, b^2 by cycle
  always_comb begin
    idx = (cnt < 3'd3) ? cnt[1:0] : 2'(cnt - 3'd3);
    oc_sel = (idx == 2'd0) ? o[0] : (idx == 2'd1) ? o[1] : o[2];
    d_sel = (idx == 2'd0) ? d[0] : (idx == 2'd1) ? d[1] : d[2];
    bsat = (b > A_MAX) ? W_MAX : (b < A_MIN) ? W_MIN : b[WIDTH-1:0];
    ma = (cnt < 3'd6) ? oc_sel : (cnt == 3'd6) ? r : bsat;
    mb = (cnt < 3'd3) ? d_sel : (cnt < 3'd6) ? oc_sel : (cnt == 3'd6) ? r : bsat;
    prod = ma * mb;
    prod_sh = $signed(AW'(prod)) >>> 4;
    dnext = prod_sh - acc;
    dclamp = dnext[AW-1] ? '0 : (dnext > A_MAX) ? W_MAX : dnext[WIDTH-1:0];
    rem_sh = {rem[RW-3:0], rad[RW-1:RW-2]};
    trial = {{(RW-SW-2){1'b0}}, root, 2'b01};
    nb = -(WIDTH+2)'(bsat);
    t0 = nb - $signed((WIDTH+2)'(root));
    t1 = nb + $signed((WIDTH+2)'(root));
    sel_hit = !disc[AW-1] && (t0 > 0 || t1 > 0);
    tsel = (t0 > 0) ? t0 : t1;
    t_sat = (tsel > T_MAX) ? W_MAX : tsel[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        o[i] <= '0;
        d[i] <= '0;
        c[i] <= '0;
      end
      r <= '0;
      tag <= '0;
      cnt <= '0;
      b <= '0;
      acc <= '0;
      disc <= '0;
      rad <= '0;
      rem <= '0;
      root <= '0;
      outValid <= 1'b0;
      hit <= 1'b0;
      tHit <= '0;
      outTag <= '0;
    end else begin
      case (state)
        IDLE: if (inValid) begin
          o[0] <= ox; o[1] <= oy; o[2] <= oz;
          d[0] <= dx; d[1] <= dy; d[2] <= dz;
          c[0] <= cx; c[1] <= cy; c[2] <= cz;
          r <= radius;
          tag <= inTag;
          cnt <= '0;
          b <= '0;
          acc <= '0;
        end
        SUB: for (int i = 0; i < 3; i++) o[i] <= o[i] - c[i];
        MAC: begin
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) b <= b + prod_sh;
          else if (cnt < 3'd6) acc <= acc + prod_sh;
          else if (cnt == 3'd6) acc <= acc - prod_sh;
          else begin
            disc <= dnext;
            rad <= {dclamp, 4'b0};
            rem <= '0;
            root <= '0;
          end
        end
        SQRT: begin
          cnt <= cnt + 3'd1;
          rad <= rad << 2;
          rem <= (rem_sh >= trial) ? rem_sh - trial : rem_sh;
          root <= {root[SW-2:0], rem_sh >= trial};
        end
        SEL: begin
          hit <= sel_hit;
          tHit <= sel_hit ? t_sat : '0;
          outTag <= tag;
          outValid <= 1'b1;
        end
        DONE: if (outReady) outValid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
